// File: rtl/flash_xip_pkg.sv
// Shared types and address-window defaults for the flash XIP line buffer.
package flash_xip_pkg;

    // Buffer control states: idle/decode, then a setup/access pair per fill word, then the reply.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FILL_SETUP  = 2'd1,
        FILL_ACCESS = 2'd2,
        RESP        = 2'd3
    } state_t;

    localparam logic [31:0] FLASH_START_DEF = 32'h3000_0000;
    localparam logic [31:0] FLASH_END_DEF   = 32'h3fff_ffff;

endpackage

// File: rtl/flash_xip_line_buf.sv
// Single-line read buffer between the CPU APB fabric and the SPI flash XIP bridge.
// Hits and rejected accesses complete in the first access cycle. A miss refills the
// whole line with sequential downstream APB reads and then answers in one RESP cycle.
//
// Handshake: upstream completer follows APB. A request is decoded only in IDLE while
// s_psel & s_penable are both high, and s_paddr must stay stable until s_pready. The
// downstream requester holds m_psel for one setup cycle, then m_psel & m_penable until
// m_pready. The current FSM state is kept in the `state` signal for debug and checkers.
module flash_xip_line_buf
    import flash_xip_pkg::*;
#(
    parameter int          LINE_WORDS  = 4,
    parameter logic [31:0] FLASH_START = FLASH_START_DEF,
    parameter logic [31:0] FLASH_END   = FLASH_END_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_paddr,
    input  logic        s_psel,
    input  logic        s_penable,
    input  logic [2:0]  s_pprot,
    input  logic        s_pwrite,
    input  logic [31:0] s_pwdata,
    input  logic [3:0]  s_pstrb,
    output logic        s_pready,
    output logic [31:0] s_prdata,
    output logic        s_pslverr,
    output logic [31:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic [2:0]  m_pprot,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    input  logic        m_pready,
    input  logic [31:0] m_prdata,
    input  logic        m_pslverr,
    input  logic        flush
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            state;
    logic              valid;
    logic              err_q;
    logic              flush_pend;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  cnt;
    logic [2:0]        pprot_q;
    logic [31:0]       m_paddr_q;
    logic [31:0]       data [LINE_WORDS];

    logic              access;
    logic              in_range;
    logic              reject;
    logic              hit;
    logic              miss;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_word;
    logic [IDX_W-1:0]  cnt_next;
    logic              store_word;

    // Write data and strobes are meaningless for a read-only buffer.
    logic unused_inputs;
    assign unused_inputs = ^{s_pwdata, s_pstrb};

    assign req_tag  = s_paddr[31:IDX_W+2];
    assign req_word = s_paddr[IDX_W+1:2];
    assign cnt_next = cnt + IDX_W'(1);

    // Decode the upstream access phase into reject / hit / miss.
    always_comb begin
        access   = (state == IDLE) && s_psel && s_penable;
        in_range = (s_paddr >= FLASH_START) && (s_paddr <= FLASH_END);
        reject   = access && (s_pwrite || !in_range);
        hit      = access && !reject && valid && (tag_q == req_tag);
        miss     = access && !reject && !hit;
    end

    assign store_word = (state == FILL_ACCESS) && m_pready && !m_pslverr && !reset;

    // Upstream response: hits and rejects answer immediately, misses answer from RESP.
    always_comb begin
        s_pready  = reject || hit || (state == RESP);
        s_pslverr = reject || ((state == RESP) && err_q);
        s_prdata  = 32'd0;
        if (hit)
            s_prdata = data[req_word];
        else if ((state == RESP) && !err_q)
            s_prdata = data[req_idx];
    end

    // Downstream requester outputs follow directly from the registered state.
    always_comb begin
        m_psel    = (state == FILL_SETUP) || (state == FILL_ACCESS);
        m_penable = (state == FILL_ACCESS);
        m_paddr   = m_paddr_q;
        m_pprot   = pprot_q;
        m_pwrite  = 1'b0;
        m_pwdata  = 32'd0;
        m_pstrb   = 4'd0;
    end

    // Line storage; contents are only trusted when valid is set, so no reset is needed.
    always_ff @(posedge clock) begin
        if (store_word)
            data[cnt] <= m_prdata;
    end

    // Control FSM: decode, linear line refill, one-cycle response, flush bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= 1'b0;
            err_q      <= 1'b0;
            flush_pend <= 1'b0;
            tag_q      <= '0;
            req_idx    <= '0;
            cnt        <= '0;
            pprot_q    <= 3'd0;
            m_paddr_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A same-cycle hit is still served from the current data above.
                    if (flush)
                        valid <= 1'b0;
                    if (miss) begin
                        valid     <= 1'b0;
                        tag_q     <= req_tag;
                        req_idx   <= req_word;
                        pprot_q   <= s_pprot;
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        m_paddr_q <= {req_tag, {IDX_W{1'b0}}, 2'b00};
                        state     <= FILL_SETUP;
                    end
                end
                FILL_SETUP: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    state <= FILL_ACCESS;
                end
                FILL_ACCESS: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (m_pready) begin
                        if (m_pslverr) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (cnt == LAST_IDX) begin
                            state <= RESP;
                        end else begin
                            cnt       <= cnt_next;
                            m_paddr_q <= {tag_q, cnt_next, 2'b00};
                            state     <= FILL_SETUP;
                        end
                    end
                end
                RESP: begin
                    // A flush landing on the reply cycle also keeps the line invalid.
                    valid      <= !err_q && !flush_pend && !flush;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_xip_line_buf.sv
// Directed bench for flash_xip_line_buf with a downstream model that returns data = address.
module tb_flash_xip_line_buf;

    logic        clock;
    logic        reset;
    logic [31:0] s_paddr;
    logic        s_psel;
    logic        s_penable;
    logic [2:0]  s_pprot;
    logic        s_pwrite;
    logic [31:0] s_pwdata;
    logic [3:0]  s_pstrb;
    logic        s_pready;
    logic [31:0] s_prdata;
    logic        s_pslverr;
    logic [31:0] m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic [2:0]  m_pprot;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic        m_pready;
    logic [31:0] m_prdata;
    logic        m_pslverr;
    logic        flush;

    int          n_checks;
    int          n_fail;
    int          psel_cnt;
    int          wcnt;
    logic [31:0] err_addr;
    logic [31:0] dn_q[$];
    logic [31:0] exp_q[$];

    flash_xip_line_buf dut (
        .clock     (clock),
        .reset     (reset),
        .s_paddr   (s_paddr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pprot   (s_pprot),
        .s_pwrite  (s_pwrite),
        .s_pwdata  (s_pwdata),
        .s_pstrb   (s_pstrb),
        .s_pready  (s_pready),
        .s_prdata  (s_prdata),
        .s_pslverr (s_pslverr),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pprot   (m_pprot),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata),
        .m_pslverr (m_pslverr),
        .flush     (flush)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Downstream completer: data = address, 1-3 wait states, error on err_addr.
    initial begin
        m_pready  = 1'b0;
        m_prdata  = 32'd0;
        m_pslverr = 1'b0;
        wcnt      = 0;
        forever begin
            @(negedge clock);
            if (m_psel) psel_cnt++;
            m_pready  = 1'b0;
            m_prdata  = 32'd0;
            m_pslverr = 1'b0;
            if (m_psel && m_penable && !reset) begin
                if (wcnt == 0) wcnt = $urandom_range(2, 4);
                wcnt--;
                if (wcnt == 0) begin
                    m_pready  = 1'b1;
                    m_prdata  = m_paddr;
                    m_pslverr = (m_paddr == err_addr);
                    dn_q.push_back(m_paddr);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // One upstream APB transfer; waits counts access-phase cycles before s_pready.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr,
                            output logic [31:0] rdata, output logic err, output int waits);
        @(posedge clock); #1;
        s_paddr   = addr;
        s_pwrite  = wr;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(posedge clock); #1;
        s_penable = 1'b1;
        waits = 0;
        rdata = 32'd0;
        err   = 1'b0;
        forever begin
            @(negedge clock);
            if (s_pready) begin
                rdata = s_prdata;
                err   = s_pslverr;
                break;
            end
            waits++;
            if (waits > 200) begin
                check("xfer_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clock); #1;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pwrite  = 1'b0;
    endtask

    // Compare the downstream address log against the expected linear fill.
    task automatic check_fill(input string tag, input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
        check({tag, "_cnt"}, 32'(dn_q.size()), 32'(n));
        for (int i = 0; i < n && i < dn_q.size(); i++)
            check({tag, "_addr"}, dn_q[i], exp_q[i]);
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;
    int          psel_snap;
    int          guard;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        psel_cnt  = 0;
        err_addr  = 32'hffff_ffff;
        reset     = 1'b1;
        s_paddr   = 32'd0;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pprot   = 3'b010;
        s_pwrite  = 1'b0;
        s_pwdata  = 32'hdead_beef;
        s_pstrb   = 4'hf;
        flush     = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_pready",  32'(s_pready), 32'd0);
        check("rst_pslverr", 32'(s_pslverr), 32'd0);
        check("rst_prdata",  s_prdata, 32'd0);
        check("rst_psel",    32'(m_psel), 32'd0);
        check("rst_penable", 32'(m_penable), 32'd0);
        check("rst_maddr",   m_paddr, 32'd0);
        check("rst_mpprot",  32'(m_pprot), 32'd0);

        // 1. Cold miss
        dn_q.delete();
        apb_xfer(32'h3000_0008, 1'b0, rd, er, wt);
        check("cold_data", rd, 32'h3000_0008);
        check("cold_err", 32'(er), 32'd0);
        check("cold_lat_min", 32'(wt >= 9), 32'd1);
        check_fill("cold_fill", 32'h3000_0000, 4);
        check("cold_pprot", 32'(m_pprot), 32'(3'b010));
        check("cold_mwrite", 32'(m_pwrite), 32'd0);
        @(negedge clock);
        check("idle_pready", 32'(s_pready), 32'd0);
        check("idle_prdata", s_prdata, 32'd0);

        // 2. Hit with zero wait states and no downstream traffic
        psel_snap = psel_cnt;
        apb_xfer(32'h3000_000C, 1'b0, rd, er, wt);
        check("hit_data", rd, 32'h3000_000C);
        check("hit_waits", 32'(wt), 32'd0);
        check("hit_err", 32'(er), 32'd0);
        apb_xfer(32'h3000_0000, 1'b0, rd, er, wt);
        check("hit0_data", rd, 32'h3000_0000);
        check("hit_no_psel", 32'(psel_cnt - psel_snap), 32'd0);

        // 3. Write and out-of-range rejects
        psel_snap = psel_cnt;
        apb_xfer(32'h3000_0000, 1'b1, rd, er, wt);
        check("wr_waits", 32'(wt), 32'd0);
        check("wr_err", 32'(er), 32'd1);
        apb_xfer(32'h2000_0000, 1'b0, rd, er, wt);
        check("oor_lo_waits", 32'(wt), 32'd0);
        check("oor_lo_err", 32'(er), 32'd1);
        check("oor_lo_data", rd, 32'd0);
        apb_xfer(32'h2fff_fffc, 1'b0, rd, er, wt);
        check("oor_edge_err", 32'(er), 32'd1);
        apb_xfer(32'h4000_0000, 1'b0, rd, er, wt);
        check("oor_hi_err", 32'(er), 32'd1);
        check("reject_no_psel", 32'(psel_cnt - psel_snap), 32'd0);

        // 4. Downstream error on the third fill word
        err_addr = 32'h3000_0018;
        dn_q.delete();
        apb_xfer(32'h3000_0010, 1'b0, rd, er, wt);
        check("derr_err", 32'(er), 32'd1);
        check("derr_data", rd, 32'd0);
        check_fill("derr_fill", 32'h3000_0010, 3);
        err_addr = 32'hffff_ffff;
        dn_q.delete();
        apb_xfer(32'h3000_0010, 1'b0, rd, er, wt);
        check("rerd_err", 32'(er), 32'd0);
        check("rerd_data", rd, 32'h3000_0010);
        check_fill("rerd_fill", 32'h3000_0010, 4);

        // 5. Flush during a fill leaves the line invalid
        dn_q.delete();
        fork
            apb_xfer(32'h3000_0020, 1'b0, rd, er, wt);
            begin
                guard = 0;
                while (!(m_psel && m_penable) && guard < 100) begin
                    @(negedge clock);
                    guard++;
                end
                @(posedge clock); #1 flush = 1'b1;
                @(posedge clock); #1 flush = 1'b0;
            end
        join
        check("flfill_data", rd, 32'h3000_0020);
        check("flfill_err", 32'(er), 32'd0);
        dn_q.delete();
        apb_xfer(32'h3000_0024, 1'b0, rd, er, wt);
        check("post_flush_data", rd, 32'h3000_0024);
        check_fill("post_flush_fill", 32'h3000_0020, 4);
        apb_xfer(32'h3000_0028, 1'b0, rd, er, wt);
        check("after_refill_hit", 32'(wt), 32'd0);
        check("after_refill_data", rd, 32'h3000_0028);

        // 6. Reset in the middle of a fill
        @(posedge clock); #1;
        s_paddr   = 32'h3000_0030;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(posedge clock); #1 s_penable = 1'b1;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(m_psel && m_penable) && guard < 100);
        check("rst_mid_reached", 32'(m_psel && m_penable), 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        check("rst_mid_psel", 32'(m_psel), 32'd0);
        check("rst_mid_pready", 32'(s_pready), 32'd0);
        reset     = 1'b0;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        dn_q.delete();
        apb_xfer(32'h3000_0034, 1'b0, rd, er, wt);
        check("rst_rerd_data", rd, 32'h3000_0034);
        check_fill("rst_rerd_fill", 32'h3000_0030, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
